rob: RTL and testbench
======================

# rob

Reorder buffer for the out-of-order RISC-V core. Sits between the issue unit and the register file:
- allocates a ROB index for every issued instruction and returns it as the rename tag;
- collects results from the common data bus and forwards uncommitted values to issue;
- retires in program order, driving the register-file write port and the rollback strobe on branch mispredict.

## Interface
- ROB_BIT, default 4: index width; usable entries are indices 1..2^ROB_BIT-1. Index 0 is reserved as "no producer / value ready".
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- id_alloc_ena  in  1  allocate one entry this cycle
- id_alloc_wr  in  1  instruction writes id_alloc_rd
- id_alloc_rd  in  5  destination register
- id_alloc_pc  in  32  instruction PC (for debug/commit trace)
- id_alloc_idx  out  ROB_BIT  index that will be allocated (= tail); combinational
- rob_full  out  1  no free entry; combinational from registered count
- id_qry1_idx / id_qry2_idx  in  ROB_BIT  producer tags from regfile
- id_qry1_rdy / id_qry2_rdy  out  1  tag 0, or entry result present (incl. same-cycle CDB hit)
- id_qry1_val / id_qry2_val  out  32  forwarded value when rdy
- cdb_ena  in  1  result broadcast
- cdb_idx  in  ROB_BIT  producing entry
- cdb_val  in  32  result
- cdb_br_miss  in  1  entry is a mispredicted control transfer
- cdb_br_pc  in  32  correct next PC, valid with cdb_br_miss
- rob_wr_ena  out  1  commit writes register; registered, 1-cycle pulse
- rob_wr_rd  out  5  committed destination
- rob_wr_val  out  32  committed value
- rob_rb  out  1  rollback pulse; registered
- rob_rb_pc  out  32  redirect PC, valid with rob_rb

## Operation
- State:
  - per entry: busy, done, wr, rd, val, miss, tgt_pc, pc;
  - head, tail pointers;
  - count, range 0..2^ROB_BIT-1.
- Pointer advance: successor of 2^ROB_BIT-1 is 1 (index 0 never allocated).
- Allocate: requires id_alloc_ena && !rob_full. Effect:
  - entry[tail] gets busy=1, done=0, plus fields;
  - tail advances, count+1.
  - id_alloc_ena while full: ignored; issue must hold.
- Writeback: requires cdb_ena to a busy entry. Effect: done=1, val, miss, tgt_pc latched. Writeback to a non-busy entry is ignored.
- Query priority: tag 0, then CDB same-cycle match, then entry done. Otherwise rdy=0, val=0.
- Commit: at most one per cycle, when entry[head] busy && done.
  - rob_wr_ena = wr && rd!=0; rd/val from entry.
  - head advances, count-1.
- Mispredict commit (miss=1):
  - rob_rb=1, rob_rb_pc=tgt_pc; rob_wr_* as a normal commit.
  - All entries cleared; head=tail=1, count=0.
  - Allocation in the same cycle is discarded.
- Simultaneous allocate and commit: both happen; count unchanged. rob_full uses pre-edge count, so a full ROB refuses allocation even while committing.
- rdy=0: no allocate, writeback or commit. rob_wr_ena and rob_rb read 0 that cycle.

## Timing
- Reset values:
  - head=tail=1, count=0, all busy=0;
  - rob_wr_ena=0, rob_wr_rd=0, rob_wr_val=0, rob_rb=0, rob_rb_pc=0;
  - rob_full=0, id_alloc_idx=1.
- Allocate at edge N: entry visible as busy after N.
- CDB at edge N: commit may occur at edge N+1 at the earliest; rob_wr_* visible after N+1 for exactly one cycle.
- Query forwarding is zero-latency, including CDB bypass in the same cycle.
- rob_rb is high for exactly one cycle, coincident with any rob_wr_ena of the same commit. The register file handles both in one edge.
- rst mid-operation: all in-flight entries discarded next edge, with no commit pulse.

## Test plan
- Reset, then allocate 3 entries (rd=1,2,3): id_alloc_idx returns 1,2,3; count=3; rob_full=0.
- Fill 15 entries at ROB_BIT=4: rob_full=1; a 16th allocate is ignored. Commit one and allocate one: tail wraps 15->1 and next id_alloc_idx=1.
- Out-of-order CDB for idx 3 then 1 then 2 (vals 0x30, 0x10, 0x20): commits in order rd1=0x10, rd2=0x20, rd3=0x30 on consecutive cycles.
- Query idx 2 in the same cycle as cdb_idx=2, val 0xAB: id_qry1_rdy=1, val=0xAB. Query idx 0: rdy=1, val=0.
- Branch at idx 2 with cdb_br_miss=1, pc 0x100, idx 3-5 busy: commit of idx 2 gives rob_rb=1, rob_rb_pc=0x100 for one cycle. Afterwards count=0 and id_alloc_idx=1; idx 3-5 never commit.
- Commit of wr=1, rd=0 entry: rob_wr_ena=0. Hold rdy=0 for 3 cycles with a done head: no commit until rdy returns.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: allocates in-order rename tags, collects CDB results,
// forwards uncommitted values to issue and retires strictly in program order.
// Index 0 is never allocated; it means "no producer / value ready".

package rob_pkg;
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        miss;
        logic [31:0] tgt_pc;
        logic [31:0] pc;
    } rob_ent_t;
endpackage

// One ROB slot. Strobes arrive already qualified by the top level
// (rdy, busy check, pointer match), so this only sequences its own fields.
module rob_entry
    import rob_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        alloc,
    input  logic        alloc_wr,
    input  logic [4:0]  alloc_rd,
    input  logic [31:0] alloc_pc,
    input  logic        wb,
    input  logic [31:0] wb_val,
    input  logic        wb_miss,
    input  logic [31:0] wb_pc,
    input  logic        retire,
    output rob_ent_t    q
);
    // Flush and reset dominate; allocate and retire never target the same
    // slot in one cycle (that needs head==tail, i.e. empty or full).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q.busy <= 1'b0;
            q.done <= 1'b0;
        end else if (alloc) begin
            q.busy <= 1'b1;
            q.done <= 1'b0;
            q.wr   <= alloc_wr;
            q.rd   <= alloc_rd;
            q.pc   <= alloc_pc;
            q.miss <= 1'b0;
        end else if (retire) begin
            q.busy <= 1'b0;
            q.done <= 1'b0;
        end else if (wb) begin
            q.done   <= 1'b1;
            q.val    <= wb_val;
            q.miss   <= wb_miss;
            q.tgt_pc <= wb_pc;
        end
    end
endmodule

module rob
    import rob_pkg::*;
#(
    parameter int ROB_BIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               id_alloc_ena,
    input  logic               id_alloc_wr,
    input  logic [4:0]         id_alloc_rd,
    input  logic [31:0]        id_alloc_pc,
    output logic [ROB_BIT-1:0] id_alloc_idx,
    output logic               rob_full,
    input  logic [ROB_BIT-1:0] id_qry1_idx,
    input  logic [ROB_BIT-1:0] id_qry2_idx,
    output logic               id_qry1_rdy,
    output logic               id_qry2_rdy,
    output logic [31:0]        id_qry1_val,
    output logic [31:0]        id_qry2_val,
    input  logic               cdb_ena,
    input  logic [ROB_BIT-1:0] cdb_idx,
    input  logic [31:0]        cdb_val,
    input  logic               cdb_br_miss,
    input  logic [31:0]        cdb_br_pc,
    output logic               rob_wr_ena,
    output logic [4:0]         rob_wr_rd,
    output logic [31:0]        rob_wr_val,
    output logic               rob_rb,
    output logic [31:0]        rob_rb_pc
);
    localparam int NQ = 2;
    localparam int N  = 1 << ROB_BIT;
    localparam logic [ROB_BIT-1:0] LAST = ROB_BIT'(N - 1);
    localparam logic [ROB_BIT-1:0] ONE  = ROB_BIT'(1);

    rob_ent_t ent [N];
    logic [ROB_BIT-1:0] head, tail, count;
    rob_ent_t head_ent;
    logic commit_go, miss_commit, alloc_go, wb_go;

    // Pointer successor skips the reserved index 0.
    function automatic logic [ROB_BIT-1:0] nxt(input logic [ROB_BIT-1:0] p);
        return (p == LAST) ? ONE : p + ONE;
    endfunction

    assign ent[0]       = '0;
    assign head_ent     = ent[head];
    assign rob_full     = (count == LAST);
    assign id_alloc_idx = tail;

    assign commit_go   = rdy && head_ent.busy && head_ent.done;
    assign miss_commit = commit_go && head_ent.miss;
    // A mispredict commit throws away anything allocated alongside it.
    assign alloc_go    = rdy && id_alloc_ena && !rob_full && !miss_commit;
    assign wb_go       = rdy && cdb_ena && ent[cdb_idx].busy;

    genvar gi;
    generate
        for (gi = 1; gi < N; gi++) begin : g_ent
            rob_entry u_ent (
                .clk      (clk),
                .rst      (rst),
                .flush    (miss_commit),
                .alloc    (alloc_go && (tail == ROB_BIT'(gi))),
                .alloc_wr (id_alloc_wr),
                .alloc_rd (id_alloc_rd),
                .alloc_pc (id_alloc_pc),
                .wb       (wb_go && (cdb_idx == ROB_BIT'(gi))),
                .wb_val   (cdb_val),
                .wb_miss  (cdb_br_miss),
                .wb_pc    (cdb_br_pc),
                .retire   (commit_go && (head == ROB_BIT'(gi))),
                .q        (ent[gi])
            );
        end
    endgenerate

    // Head/tail/count bookkeeping; a mispredict commit resets to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= ONE;
            tail  <= ONE;
            count <= '0;
        end else if (rdy) begin
            if (miss_commit) begin
                head  <= ONE;
                tail  <= ONE;
                count <= '0;
            end else begin
                if (commit_go) head <= nxt(head);
                if (alloc_go)  tail <= nxt(tail);
                count <= count + (alloc_go ? ONE : '0) - (commit_go ? ONE : '0);
            end
        end
    end

    // Registered commit port and rollback strobe; pulses drop while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rob_wr_ena <= 1'b0;
            rob_wr_rd  <= '0;
            rob_wr_val <= '0;
            rob_rb     <= 1'b0;
            rob_rb_pc  <= '0;
        end else if (!rdy) begin
            rob_wr_ena <= 1'b0;
            rob_rb     <= 1'b0;
        end else begin
            rob_wr_ena <= commit_go && head_ent.wr && (head_ent.rd != 5'd0);
            rob_rb     <= miss_commit;
            if (commit_go) begin
                rob_wr_rd  <= head_ent.rd;
                rob_wr_val <= head_ent.val;
            end
            if (miss_commit) rob_rb_pc <= head_ent.tgt_pc;
        end
    end

    // Operand forwarding: tag 0, then same-cycle CDB, then stored result.
    logic [NQ-1:0][ROB_BIT-1:0] q_idx;
    logic [NQ-1:0]              q_rdy;
    logic [NQ-1:0][31:0]        q_val;

    assign q_idx = {id_qry2_idx, id_qry1_idx};

    genvar qi;
    generate
        for (qi = 0; qi < NQ; qi++) begin : g_qry
            // Combinational lookup for one query port.
            always_comb begin
                q_rdy[qi] = 1'b0;
                q_val[qi] = '0;
                if (q_idx[qi] == '0) begin
                    q_rdy[qi] = 1'b1;
                end else if (cdb_ena && cdb_idx == q_idx[qi] && ent[q_idx[qi]].busy) begin
                    q_rdy[qi] = 1'b1;
                    q_val[qi] = cdb_val;
                end else if (ent[q_idx[qi]].done) begin
                    q_rdy[qi] = 1'b1;
                    q_val[qi] = ent[q_idx[qi]].val;
                end
            end
        end
    endgenerate

    assign id_qry1_rdy = q_rdy[0];
    assign id_qry2_rdy = q_rdy[1];
    assign id_qry1_val = q_val[0];
    assign id_qry2_val = q_val[1];
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: a table of one-cycle vectors with hand-computed
// post-edge outputs, plus hand sequences for forwarding and full/wrap.
module tb_rob;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        id_alloc_ena, id_alloc_wr;
    logic [4:0]  id_alloc_rd;
    logic [31:0] id_alloc_pc;
    logic [3:0]  id_alloc_idx;
    logic        rob_full;
    logic [3:0]  id_qry1_idx, id_qry2_idx;
    logic        id_qry1_rdy, id_qry2_rdy;
    logic [31:0] id_qry1_val, id_qry2_val;
    logic        cdb_ena;
    logic [3:0]  cdb_idx;
    logic [31:0] cdb_val;
    logic        cdb_br_miss;
    logic [31:0] cdb_br_pc;
    logic        rob_wr_ena;
    logic [4:0]  rob_wr_rd;
    logic [31:0] rob_wr_val;
    logic        rob_rb;
    logic [31:0] rob_rb_pc;

    int tests = 0;
    int fails = 0;

    rob #(.ROB_BIT(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .id_alloc_ena(id_alloc_ena), .id_alloc_wr(id_alloc_wr),
        .id_alloc_rd(id_alloc_rd), .id_alloc_pc(id_alloc_pc),
        .id_alloc_idx(id_alloc_idx), .rob_full(rob_full),
        .id_qry1_idx(id_qry1_idx), .id_qry2_idx(id_qry2_idx),
        .id_qry1_rdy(id_qry1_rdy), .id_qry2_rdy(id_qry2_rdy),
        .id_qry1_val(id_qry1_val), .id_qry2_val(id_qry2_val),
        .cdb_ena(cdb_ena), .cdb_idx(cdb_idx), .cdb_val(cdb_val),
        .cdb_br_miss(cdb_br_miss), .cdb_br_pc(cdb_br_pc),
        .rob_wr_ena(rob_wr_ena), .rob_wr_rd(rob_wr_rd), .rob_wr_val(rob_wr_val),
        .rob_rb(rob_rb), .rob_rb_pc(rob_rb_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rdy, alloc, wr;
        logic [4:0]  rd;
        logic        cdb;
        logic [3:0]  cidx;
        logic [31:0] cval;
        logic        miss;
        logic [31:0] bpc;
        logic [3:0]  e_idx;
        logic        e_full, e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic        e_rb;
        logic [31:0] e_rbpc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic y, input logic a, input logic w,
                       input logic [4:0] rd, input logic c, input logic [3:0] ci,
                       input logic [31:0] cv, input logic m, input logic [31:0] bp,
                       input logic [3:0] ei, input logic ef, input logic ew,
                       input logic [4:0] erd, input logic [31:0] ev,
                       input logic erb, input logic [31:0] erp);
        vec_t v;
        v.rst = r; v.rdy = y; v.alloc = a; v.wr = w; v.rd = rd;
        v.cdb = c; v.cidx = ci; v.cval = cv; v.miss = m; v.bpc = bp;
        v.e_idx = ei; v.e_full = ef; v.e_wr = ew; v.e_rd = erd; v.e_val = ev;
        v.e_rb = erb; v.e_rbpc = erp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; rdy = 1'b1;
        id_alloc_ena = 1'b0; id_alloc_wr = 1'b0; id_alloc_rd = '0; id_alloc_pc = '0;
        id_qry1_idx = '0; id_qry2_idx = '0;
        cdb_ena = 1'b0; cdb_idx = '0; cdb_val = '0; cdb_br_miss = 1'b0; cdb_br_pc = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        chk("rst_wr_ena", 32'(rob_wr_ena), 0);
        chk("rst_wr_rd",  32'(rob_wr_rd), 0);
        chk("rst_wr_val", rob_wr_val, 0);
        chk("rst_rb",     32'(rob_rb), 0);
        chk("rst_rb_pc",  rob_rb_pc, 0);
        chk("rst_full",   32'(rob_full), 0);
        chk("rst_idx",    32'(id_alloc_idx), 1);

        //   rst y  al w  rd  cdb ci  cval  m  bpc     eidx ef ew erd  eval  erb erbpc
        // three allocs, out-of-order writeback, in-order commit
        add(0, 1, 1, 1, 1,  0, 0, 0,     0, 0,      2, 0, 0, 0, 0,     0, 0);
        add(0, 1, 1, 1, 2,  0, 0, 0,     0, 0,      3, 0, 0, 0, 0,     0, 0);
        add(0, 1, 1, 1, 3,  0, 0, 0,     0, 0,      4, 0, 0, 0, 0,     0, 0);
        add(0, 1, 0, 0, 0,  1, 3, 'h30,  0, 0,      4, 0, 0, 0, 0,     0, 0);
        add(0, 1, 0, 0, 0,  1, 1, 'h10,  0, 0,      4, 0, 0, 0, 0,     0, 0);
        add(0, 1, 0, 0, 0,  1, 2, 'h20,  0, 0,      4, 0, 1, 1, 'h10,  0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0,     0, 0,      4, 0, 1, 2, 'h20,  0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0,     0, 0,      4, 0, 1, 3, 'h30,  0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0,     0, 0,      4, 0, 0, 0, 0,     0, 0);
        // reset, five allocs, branch at idx 2 mispredicts with idx 3-5 in flight
        add(1, 1, 0, 0, 0,  0, 0, 0,     0, 0,      1, 0, 0, 0, 0,     0, 0);
        add(0, 1, 1, 1, 1,  0, 0, 0,     0, 0,      2, 0, 0, 0, 0,     0, 0);
        add(0, 1, 1, 1, 2,  0, 0, 0,     0, 0,      3, 0, 0, 0, 0,     0, 0);
        add(0, 1, 1, 1, 3,  0, 0, 0,     0, 0,      4, 0, 0, 0, 0,     0, 0);
        add(0, 1, 1, 1, 4,  0, 0, 0,     0, 0,      5, 0, 0, 0, 0,     0, 0);
        add(0, 1, 1, 1, 5,  1, 1, 'h11,  0, 0,      6, 0, 0, 0, 0,     0, 0);
        add(0, 1, 0, 0, 0,  1, 2, 'h22,  1, 'h100,  6, 0, 1, 1, 'h11,  0, 0);
        add(0, 1, 1, 1, 6,  1, 3, 'h33,  0, 0,      1, 0, 1, 2, 'h22,  1, 'h100);
        add(0, 1, 0, 0, 0,  1, 4, 'h44,  0, 0,      1, 0, 0, 0, 0,     0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0,     0, 0,      1, 0, 0, 0, 0,     0, 0);
        // wr=1 with rd=0 retires silently; next entry proves head moved on
        add(0, 1, 1, 1, 0,  0, 0, 0,     0, 0,      2, 0, 0, 0, 0,     0, 0);
        add(0, 1, 0, 0, 0,  1, 1, 'h55,  0, 0,      2, 0, 0, 0, 0,     0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0,     0, 0,      2, 0, 0, 0, 0,     0, 0);
        add(0, 1, 1, 1, 7,  0, 0, 0,     0, 0,      3, 0, 0, 0, 0,     0, 0);
        add(0, 1, 0, 0, 0,  1, 2, 'h77,  0, 0,      3, 0, 0, 0, 0,     0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0,     0, 0,      3, 0, 1, 7, 'h77,  0, 0);
        // rdy low for 3 cycles with a done head: nothing moves
        add(0, 1, 1, 1, 8,  0, 0, 0,     0, 0,      4, 0, 0, 0, 0,     0, 0);
        add(0, 1, 0, 0, 0,  1, 3, 'h88,  0, 0,      4, 0, 0, 0, 0,     0, 0);
        add(0, 0, 1, 1, 9,  0, 0, 0,     0, 0,      4, 0, 0, 0, 0,     0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0,     0, 0,      4, 0, 0, 0, 0,     0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0,     0, 0,      4, 0, 0, 0, 0,     0, 0);
        add(0, 1, 0, 0, 0,  0, 0, 0,     0, 0,      4, 0, 1, 8, 'h88,  0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; rdy = vecs[i].rdy;
            id_alloc_ena = vecs[i].alloc; id_alloc_wr = vecs[i].wr;
            id_alloc_rd = vecs[i].rd; id_alloc_pc = 32'h1000 + 32'(i * 4);
            cdb_ena = vecs[i].cdb; cdb_idx = vecs[i].cidx; cdb_val = vecs[i].cval;
            cdb_br_miss = vecs[i].miss; cdb_br_pc = vecs[i].bpc;
            tick();
            chk($sformatf("v%0d_idx", i),    32'(id_alloc_idx), 32'(vecs[i].e_idx));
            chk($sformatf("v%0d_full", i),   32'(rob_full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d_wr_ena", i), 32'(rob_wr_ena), 32'(vecs[i].e_wr));
            chk($sformatf("v%0d_rb", i),     32'(rob_rb), 32'(vecs[i].e_rb));
            if (vecs[i].e_wr) begin
                chk($sformatf("v%0d_wr_rd", i),  32'(rob_wr_rd), 32'(vecs[i].e_rd));
                chk($sformatf("v%0d_wr_val", i), rob_wr_val, vecs[i].e_val);
            end
            if (vecs[i].e_rb)
                chk($sformatf("v%0d_rb_pc", i), rob_rb_pc, vecs[i].e_rbpc);
        end
        idle_inputs();

        // Forwarding: head=tail=4, empty. Allocate idx 4.
        id_alloc_ena = 1'b1; id_alloc_wr = 1'b1; id_alloc_rd = 5'd9;
        tick();
        id_alloc_ena = 1'b0;
        id_qry1_idx = 4'd4; id_qry2_idx = 4'd4;
        #1;
        chk("q_pending_rdy", 32'(id_qry1_rdy), 0);
        chk("q_pending_val", id_qry1_val, 0);
        cdb_ena = 1'b1; cdb_idx = 4'd4; cdb_val = 32'hAB; id_qry2_idx = 4'd0;
        #1;
        chk("q_bypass_rdy", 32'(id_qry1_rdy), 1);
        chk("q_bypass_val", id_qry1_val, 32'hAB);
        chk("q_zero_rdy",   32'(id_qry2_rdy), 1);
        chk("q_zero_val",   id_qry2_val, 0);
        tick();
        cdb_ena = 1'b0; cdb_val = '0;
        #1;
        chk("q_done_rdy", 32'(id_qry1_rdy), 1);
        chk("q_done_val", id_qry1_val, 32'hAB);
        tick();
        chk("q_commit_wr", 32'(rob_wr_ena), 1);
        chk("q_retired_rdy", 32'(id_qry1_rdy), 0);
        idle_inputs();

        // Fill all 15 entries, then wrap.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            id_alloc_ena = 1'b1; id_alloc_wr = 1'b1; id_alloc_rd = 5'(k);
            #1;
            chk($sformatf("fill_idx%0d", k), 32'(id_alloc_idx), 32'(k));
            tick();
        end
        chk("full_set", 32'(rob_full), 1);
        chk("full_wrap_idx", 32'(id_alloc_idx), 1);
        tick();
        chk("full_ignore_idx", 32'(id_alloc_idx), 1);
        chk("full_ignore_full", 32'(rob_full), 1);
        id_alloc_ena = 1'b0;
        cdb_ena = 1'b1; cdb_idx = 4'd1; cdb_val = 32'h5A;
        tick();
        cdb_ena = 1'b0;
        id_alloc_ena = 1'b1; id_alloc_rd = 5'd20;
        tick();
        chk("full_commit_wr", 32'(rob_wr_ena), 1);
        chk("full_commit_val", rob_wr_val, 32'h5A);
        chk("full_refused_idx", 32'(id_alloc_idx), 1);
        chk("full_after_commit", 32'(rob_full), 0);
        tick();
        id_alloc_ena = 1'b0;
        chk("wrap_alloc_idx", 32'(id_alloc_idx), 2);
        chk("wrap_refull", 32'(rob_full), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
